adder_n_bit_sequential: RTL and testbench

ADDER_N_BIT_SEQUENTIAL -- requirements
Module: adder_n_bit_sequential

---
 rtl/adder_n_bit_sequential.sv | 110 +++++++++++
 tb/tb_adder_n_bit_sequential.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adder_n_bit_sequential.sv
// Multi-cycle two's complement adder/subtractor: adds CHUNK bits per clock,
// then applies the selected overflow policy when the last chunk completes.
module adder_n_bit_sequential #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | adding one chunk per clock, index idx
  // DONE  | result valid this cycle; start here is accepted back-to-back
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] raw_r;
  logic             carry;
  logic [1:0]       mode_r;
  logic [IDXW-1:0]  idx;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] raw_next;
  logic             ovf_next;
  logic [WIDTH-1:0] result_next;

  always_comb begin
    chunk_sum = {1'b0, a_r[idx*CHUNK +: CHUNK]} + {1'b0, b_r[idx*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    raw_next = raw_r;
    raw_next[idx*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    // Only meaningful on the last chunk, when the MSB of raw_next is final.
    ovf_next = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (raw_next[WIDTH-1] != a_r[WIDTH-1]);
    case (mode_r)
      2'b01:   result_next = ovf_next ? '0 : raw_next;
      2'b10:   result_next = !ovf_next ? raw_next :
                             (a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}});
      default: result_next = raw_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      carry    <= 1'b0;
      idx      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      raw_r    <= '0;
      mode_r   <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= sub ? ~b : b;
            carry  <= sub;
            mode_r <= mode;
            idx    <= '0;
            raw_r  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          raw_r <= raw_next;
          carry <= chunk_sum[CHUNK];
          if (idx == LAST) begin
            sum      <= result_next;
            c_out    <= chunk_sum[CHUNK];
            overflow <= ovf_next;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_n_bit_sequential.sv
// Self-checking bench for adder_n_bit_sequential (WIDTH=16, CHUNK=4):
// directed corner cases plus random operations against an arithmetic model.
module tb_adder_n_bit_sequential;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        c_out;
  logic        overflow;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_sum;
  logic        exp_c;
  logic        exp_ov;
  logic [15:0] held_sum;

  adder_n_bit_sequential #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sub(sub),
    .mode(mode), .busy(busy), .done(done), .sum(sum), .c_out(c_out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: true signed arithmetic for overflow, unsigned compare for carry.
  task automatic model(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                       input logic [1:0] tm);
    int ua, ub, sa, sb, r;
    logic [15:0] raw;
    ua = int'(ta);
    ub = int'(tb_);
    sa = int'($signed(ta));
    sb = int'($signed(tb_));
    if (ts) begin
      raw   = 16'(ua - ub);
      exp_c = (ua >= ub);
      r     = sa - sb;
    end else begin
      raw   = 16'(ua + ub);
      exp_c = ((ua + ub) > 65535);
      r     = sa + sb;
    end
    exp_ov = (r > 32767) || (r < -32768);
    if (tm == 2'b01 && exp_ov)      exp_sum = 16'h0000;
    else if (tm == 2'b10 && exp_ov) exp_sum = ta[15] ? 16'h8000 : 16'h7FFF;
    else                            exp_sum = raw;
  endtask

  // Called at a negedge; returns one negedge after the start edge, with
  // operand inputs scrambled to prove they are ignored during RUN.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                       input logic [1:0] tm);
    model(ta, tb_, ts, tm);
    a = ta; b = tb_; sub = ts; mode = tm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); mode = 2'($urandom);
    check("busy_after_start", busy, 1);
    check("no_done_at_start", done, 0);
  endtask

  task automatic wait_check(input int remaining, input string tag);
    int   k;
    logic got;
    k = 0;
    got = 1'b0;
    while (k < 20 && !got) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) got = 1'b1;
      else check({tag, "_sum_before_done"}, sum, held_sum);
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_latency"}, k, remaining);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_c_out"}, c_out, exp_c);
    check({tag, "_overflow"}, overflow, exp_ov);
    check({tag, "_busy_low"}, busy, 0);
    held_sum = exp_sum;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0; mode = 2'b00;
    held_sum = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(16'h7FFF, 16'h0001, 1'b0, 2'b00); wait_check(4, "wrap_pos_ovf");
    issue(16'h7FFF, 16'h0001, 1'b0, 2'b01); wait_check(4, "zero_ovf");
    issue(16'h7FFF, 16'h0001, 1'b0, 2'b10); wait_check(4, "sat_pos");
    issue(16'h8000, 16'h0001, 1'b1, 2'b10); wait_check(4, "sat_neg_sub");
    issue(16'hFFFF, 16'h0001, 1'b0, 2'b00); wait_check(4, "carry_no_ovf");
    issue(16'h8000, 16'h8000, 1'b0, 2'b11); wait_check(4, "mode11_wrap");

    repeat (2) begin
      @(negedge clk);
      check("idle_no_done", done, 0);
      check("idle_sum_hold", sum, held_sum);
      check("idle_busy", busy, 0);
    end

    // Second start during RUN must be ignored.
    issue(16'h1234, 16'h1111, 1'b0, 2'b00);
    @(negedge clk);
    a = 16'h0001; b = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_check(2, "ignored_start");
    check("ignored_start_value", sum, 16'h2345);
    // Start in the DONE cycle.
    issue(16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom));
    wait_check(4, "back_to_back");

    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk);
        check("gap_no_done", done, 0);
        check("gap_sum_hold", sum, held_sum);
      end
      issue(16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom));
      wait_check(4, "random");
    end

    // Abort two cycles into RUN.
    issue(16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_c_out", c_out, 0);
    check("abort_overflow", overflow, 0);
    held_sum = '0;
    repeat (8) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end

    issue(16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom));
    wait_check(4, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
